// File: rtl/throw_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : throw_sequencer_pkg
//  Description : Shared game definitions: sequencer states and PS/2 scan codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package throw_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AIM    = 3'd1,
        S_POWER  = 3'd2,
        S_LAUNCH = 3'd3,
        S_ROLL   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [7:0] c_KEY_LEFT  = 8'h1C;   // 'A'
    localparam logic [7:0] c_KEY_RIGHT = 8'h23;   // 'D'
    localparam logic [7:0] c_KEY_SPACE = 8'h29;
    localparam logic [7:0] c_KEY_BREAK = 8'hF0;

    // True for the two keys that steer the aim arrow
    function automatic logic is_arrow_key(input logic [7:0] code);
        return (code == c_KEY_LEFT) || (code == c_KEY_RIGHT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/throw_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : throw_sequencer_if
//  Description : Keyboard / aim / lane signals of the throw sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface throw_sequencer_if;

    logic [7:0] scan_code;
    logic       scan_valid;
    logic       tick;
    logic [3:0] x_pos;
    logic       ball_done;

    logic       arrow_en;
    logic [7:0] arrow_dir;
    logic [3:0] power;
    logic       launch;
    logic [3:0] launch_pos;
    logic [3:0] launch_pow;
    logic [3:0] frame;
    logic       ball;
    logic       game_over;

    // Sequencer side
    modport slave (
        input  scan_code, scan_valid, tick, x_pos, ball_done,
        output arrow_en, arrow_dir, power, launch, launch_pos, launch_pow,
               frame, ball, game_over
    );

    // Environment side (keyboard, rate divider, aim block, lane logic)
    modport master (
        output scan_code, scan_valid, tick, x_pos, ball_done,
        input  arrow_en, arrow_dir, power, launch, launch_pos, launch_pow,
               frame, ball, game_over
    );

endinterface
`default_nettype wire

// File: rtl/throw_sequencer_ps2_make_filter.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_make_filter
//  Description : Passes PS/2 make codes; swallows F0 and the byte after it.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_make_filter
    import throw_sequencer_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic [7:0] i_scan_code,
    input  wire logic       i_scan_valid,
    output logic            o_make_valid,
    output logic [7:0]      o_make_code
);

    logic r_break_pending;

    // Arm on F0; the next received byte (whatever it is) disarms it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_break_pending <= 1'b0;
        end else if (i_scan_valid) begin
            r_break_pending <= !r_break_pending && (i_scan_code == c_KEY_BREAK);
        end
    end

    assign o_make_valid = i_scan_valid && !r_break_pending && (i_scan_code != c_KEY_BREAK);
    assign o_make_code  = i_scan_code;

endmodule
`default_nettype wire

// File: rtl/throw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : throw_sequencer
//  Description : Bowling throw sequencer: aim, power meter, launch, roll and
//                frame/ball bookkeeping driven by PS/2 make codes.
//  Revision    : 1.0 - initial release
// ============================================================================
module throw_sequencer
    import throw_sequencer_pkg::*;
#(
    parameter int POWER_MAX  = 15,
    parameter int NUM_FRAMES = 10
)(
    input  wire logic        CLOCK_50,
    input  wire logic        reset,
    throw_sequencer_if.slave bus
);

    localparam logic [3:0] c_POWER_MAX  = 4'(POWER_MAX);
    localparam logic [3:0] c_NUM_FRAMES = 4'(NUM_FRAMES);

    logic       w_make_valid;
    logic [7:0] w_make_code;
    logic       w_space;

    state_t     r_state,      w_state_nxt;
    logic       r_arrow_en,   w_arrow_en_nxt;
    logic [7:0] r_arrow_dir,  w_arrow_dir_nxt;
    logic [3:0] r_power,      w_power_nxt;
    logic       r_up,         w_up_nxt;
    logic [3:0] r_launch_pos, w_launch_pos_nxt;
    logic [3:0] r_launch_pow, w_launch_pow_nxt;
    logic [3:0] r_frame,      w_frame_nxt;
    logic       r_ball,       w_ball_nxt;

    ps2_make_filter u_make_filter (
        .clk          (CLOCK_50),
        .rst_n        (reset),
        .i_scan_code  (bus.scan_code),
        .i_scan_valid (bus.scan_valid),
        .o_make_valid (w_make_valid),
        .o_make_code  (w_make_code)
    );

    assign w_space = w_make_valid && (w_make_code == c_KEY_SPACE);

    // State and all sequencer outputs; reset aborts any throw in progress
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_arrow_en   <= 1'b0;
            r_arrow_dir  <= 8'h00;
            r_power      <= 4'd0;
            r_up         <= 1'b1;
            r_launch_pos <= 4'd0;
            r_launch_pow <= 4'd0;
            r_frame      <= 4'd1;
            r_ball       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_arrow_en   <= w_arrow_en_nxt;
            r_arrow_dir  <= w_arrow_dir_nxt;
            r_power      <= w_power_nxt;
            r_up         <= w_up_nxt;
            r_launch_pos <= w_launch_pos_nxt;
            r_launch_pow <= w_launch_pow_nxt;
            r_frame      <= w_frame_nxt;
            r_ball       <= w_ball_nxt;
        end
    end

    // Next-state and next-output decode; arrow strobe defaults low every cycle
    always_comb begin
        w_state_nxt      = r_state;
        w_arrow_en_nxt   = 1'b0;
        w_arrow_dir_nxt  = 8'h00;
        w_power_nxt      = r_power;
        w_up_nxt         = r_up;
        w_launch_pos_nxt = r_launch_pos;
        w_launch_pow_nxt = r_launch_pow;
        w_frame_nxt      = r_frame;
        w_ball_nxt       = r_ball;

        case (r_state)
            S_IDLE: begin
                if (w_space) begin
                    w_state_nxt = S_AIM;
                end
            end

            S_AIM: begin
                if (w_make_valid && is_arrow_key(w_make_code)) begin
                    w_arrow_en_nxt  = 1'b1;
                    w_arrow_dir_nxt = w_make_code;
                end else if (w_space) begin
                    w_launch_pos_nxt = bus.x_pos;
                    w_power_nxt      = 4'd0;
                    w_up_nxt         = 1'b1;
                    w_state_nxt      = S_POWER;
                end
            end

            S_POWER: begin
                // Confirm wins over a coincident tick so the latched value is
                // exactly what the player saw
                if (w_space) begin
                    w_launch_pow_nxt = r_power;
                    w_state_nxt      = S_LAUNCH;
                end else if (bus.tick) begin
                    if (r_up) begin
                        if (r_power >= c_POWER_MAX) begin
                            w_power_nxt = r_power - 4'd1;
                            w_up_nxt    = 1'b0;
                        end else begin
                            w_power_nxt = r_power + 4'd1;
                        end
                    end else begin
                        if (r_power == 4'd0) begin
                            w_power_nxt = 4'd1;
                            w_up_nxt    = 1'b1;
                        end else begin
                            w_power_nxt = r_power - 4'd1;
                        end
                    end
                end
            end

            S_LAUNCH: begin
                w_state_nxt = S_ROLL;
            end

            S_ROLL: begin
                if (bus.ball_done) begin
                    if (!r_ball) begin
                        w_ball_nxt  = 1'b1;
                        w_state_nxt = S_AIM;
                    end else if (r_frame >= c_NUM_FRAMES) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_ball_nxt  = 1'b0;
                        w_frame_nxt = r_frame + 4'd1;
                        w_state_nxt = S_AIM;
                    end
                end
            end

            S_DONE: begin
                if (w_space) begin
                    w_frame_nxt = 4'd1;
                    w_ball_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.arrow_en   = r_arrow_en;
    assign bus.arrow_dir  = r_arrow_dir;
    assign bus.power      = r_power;
    assign bus.launch     = (r_state == S_LAUNCH);
    assign bus.launch_pos = r_launch_pos;
    assign bus.launch_pow = r_launch_pow;
    assign bus.frame      = r_frame;
    assign bus.ball       = r_ball;
    assign bus.game_over  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_throw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_throw_sequencer
//  Description : Self-checking bench for throw_sequencer with a game-level
//                reference model (throw count, tick count -> power formula).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_throw_sequencer;

    localparam int P_MAX = 15;
    localparam int N_FR  = 2;

    localparam int MS_IDLE   = 0;
    localparam int MS_AIM    = 1;
    localparam int MS_POWER  = 2;
    localparam int MS_LAUNCH = 3;
    localparam int MS_ROLL   = 4;
    localparam int MS_DONE   = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    throw_sequencer_if u_if ();

    throw_sequencer #(
        .POWER_MAX  (P_MAX),
        .NUM_FRAMES (N_FR)
    ) u_dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (u_if.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: game mode, completed throws, ticks seen since power start
    int         m_mode;
    int         m_ticks;
    int         m_throws;
    bit         m_brk;
    logic [3:0] m_pos;
    logic [3:0] m_pow;
    logic       e_arrow_en;
    logic [7:0] e_arrow_dir;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Triangle wave: n ticks after starting at 0 going up
    function automatic int pow_of(input int n);
        int r;
        r = n % (2 * P_MAX);
        return (r <= P_MAX) ? r : (2 * P_MAX - r);
    endfunction

    function automatic int exp_frame();
        if (m_throws >= 2 * N_FR) return N_FR;
        return m_throws / 2 + 1;
    endfunction

    function automatic int exp_ball();
        if (m_throws >= 2 * N_FR) return 1;
        return m_throws % 2;
    endfunction

    task automatic model_reset();
        m_mode      = MS_IDLE;
        m_ticks     = 0;
        m_throws    = 0;
        m_brk       = 1'b0;
        m_pos       = 4'd0;
        m_pow       = 4'd0;
        e_arrow_en  = 1'b0;
        e_arrow_dir = 8'h00;
    endtask

    task automatic compare_all();
        check("arrow_en",   32'(u_if.arrow_en),   32'(e_arrow_en));
        check("arrow_dir",  32'(u_if.arrow_dir),  32'(e_arrow_dir));
        check("power",      32'(u_if.power),      pow_of(m_ticks));
        check("launch",     32'(u_if.launch),     32'(m_mode == MS_LAUNCH));
        check("launch_pos", 32'(u_if.launch_pos), 32'(m_pos));
        check("launch_pow", 32'(u_if.launch_pow), 32'(m_pow));
        check("frame",      32'(u_if.frame),      exp_frame());
        check("ball",       32'(u_if.ball),       exp_ball());
        check("game_over",  32'(u_if.game_over),  32'(m_mode == MS_DONE));
    endtask

    // One clock cycle: apply inputs, advance the model, compare after the edge
    task automatic cyc(input bit v, input logic [7:0] c, input bit t, input bit d,
                       input logic [3:0] x);
        bit mk;
        u_if.scan_valid = v;
        u_if.scan_code  = c;
        u_if.tick       = t;
        u_if.ball_done  = d;
        u_if.x_pos      = x;

        mk = v && !m_brk && (c != 8'hF0);
        if (v) m_brk = !m_brk && (c == 8'hF0);
        e_arrow_en  = 1'b0;
        e_arrow_dir = 8'h00;

        case (m_mode)
            MS_IDLE: if (mk && c == 8'h29) m_mode = MS_AIM;
            MS_AIM: begin
                if (mk && (c == 8'h1C || c == 8'h23)) begin
                    e_arrow_en  = 1'b1;
                    e_arrow_dir = c;
                end else if (mk && c == 8'h29) begin
                    m_pos   = x;
                    m_ticks = 0;
                    m_mode  = MS_POWER;
                end
            end
            MS_POWER: begin
                if (mk && c == 8'h29) begin
                    m_pow  = 4'(pow_of(m_ticks));
                    m_mode = MS_LAUNCH;
                end else if (t) begin
                    m_ticks++;
                end
            end
            MS_LAUNCH: m_mode = MS_ROLL;
            MS_ROLL: begin
                if (d) begin
                    m_throws++;
                    m_mode = (m_throws == 2 * N_FR) ? MS_DONE : MS_AIM;
                end
            end
            default: begin
                if (mk && c == 8'h29) begin
                    m_throws = 0;
                    m_mode   = MS_IDLE;
                end
            end
        endcase

        @(posedge clk);
        #1;
        u_if.scan_valid = 1'b0;
        u_if.tick       = 1'b0;
        u_if.ball_done  = 1'b0;
        compare_all();
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
    endtask

    // Full throw from AIM: confirm aim, n ticks, confirm power, launch, roll done
    task automatic throw(input logic [3:0] x, input int n);
        cyc(1'b1, 8'h29, 1'b0, 1'b0, x);
        repeat (n) cyc(1'b0, 8'h00, 1'b1, 1'b0, x);
        cyc(1'b1, 8'h29, 1'b0, 1'b0, x);
        idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b1, x);
    endtask

    // Reset asserted between clock edges must take effect without a clock
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_arrow_en",   32'(u_if.arrow_en),   32'd0);
        check("rst_arrow_dir",  32'(u_if.arrow_dir),  32'd0);
        check("rst_power",      32'(u_if.power),      32'd0);
        check("rst_launch",     32'(u_if.launch),     32'd0);
        check("rst_launch_pos", 32'(u_if.launch_pos), 32'd0);
        check("rst_launch_pow", 32'(u_if.launch_pow), 32'd0);
        check("rst_frame",      32'(u_if.frame),      32'd1);
        check("rst_ball",       32'(u_if.ball),       32'd0);
        check("rst_game_over",  32'(u_if.game_over),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        u_if.scan_valid = 1'b0;
        u_if.scan_code  = 8'h00;
        u_if.tick       = 1'b0;
        u_if.x_pos      = 4'd0;
        u_if.ball_done  = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset_frame", 32'(u_if.frame), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_all();

        // Space, A, A, D: three single-cycle arrow pulses
        cyc(1'b1, 8'h29, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 8'h1C, 1'b0, 1'b0, 4'd0);
        check("aim_a1_en",  32'(u_if.arrow_en),  32'd1);
        check("aim_a1_dir", 32'(u_if.arrow_dir), 32'h1C);
        idle();
        cyc(1'b1, 8'h1C, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 8'h23, 1'b0, 1'b0, 4'd0);
        check("aim_d_dir",  32'(u_if.arrow_dir), 32'h23);
        idle();
        check("aim_d_off",  32'(u_if.arrow_en),  32'd0);

        // A then break of A: only one pulse
        cyc(1'b1, 8'h1C, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 8'hF0, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 8'h1C, 1'b0, 1'b0, 4'd0);
        check("break_discard", 32'(u_if.arrow_en), 32'd0);
        idle();

        // Power meter: 20 ticks -> 10, confirm with a coincident tick
        cyc(1'b1, 8'h29, 1'b0, 1'b0, 4'd7);
        repeat (20) cyc(1'b0, 8'h00, 1'b1, 1'b0, 4'd3);
        check("power_20", 32'(u_if.power), 32'd10);
        cyc(1'b1, 8'h29, 1'b1, 1'b0, 4'd3);
        check("launch_pos7",  32'(u_if.launch_pos), 32'd7);
        check("launch_pow10", 32'(u_if.launch_pow), 32'd10);
        check("launch_hi",    32'(u_if.launch),     32'd1);
        idle();
        check("launch_lo",    32'(u_if.launch),     32'd0);

        // Ball/frame advance
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 4'd0);
        check("ball1",   32'(u_if.ball),  32'd1);
        throw(4'd2, 5);
        check("ball0",   32'(u_if.ball),  32'd0);
        check("frame2",  32'(u_if.frame), 32'd2);

        // Finish the 2-frame game, then restart
        throw(4'd9, 3);
        throw(4'd4, 30);
        check("game_over", 32'(u_if.game_over), 32'd1);
        cyc(1'b1, 8'h29, 1'b0, 1'b0, 4'd0);
        check("restart_frame", 32'(u_if.frame),     32'd1);
        check("restart_go",    32'(u_if.game_over), 32'd0);

        // Reset in POWER at power 6
        cyc(1'b1, 8'h29, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 8'h29, 1'b0, 1'b0, 4'd5);
        repeat (6) cyc(1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
        check("power_6", 32'(u_if.power), 32'd6);
        async_reset();

        // Randomized play
        for (int i = 0; i < 4000; i++) begin
            bit         v;
            logic [7:0] c;
            int         k;
            v = ($urandom_range(0, 99) < 30);
            k = $urandom_range(0, 6);
            case (k)
                0:       c = 8'h1C;
                1:       c = 8'h23;
                2, 3:    c = 8'h29;
                4:       c = 8'hF0;
                default: c = 8'($urandom);
            endcase
            cyc(v, c, $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 15, 4'($urandom));
            if (i % 1000 == 999) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/throw_sequencer.md
THROW_SEQUENCER -- requirements
Module: throw_sequencer

Interface
REQ-001 Parameter POWER_MAX, default 15, is the top of the power-meter sweep (range 1..15).
REQ-002 Parameter NUM_FRAMES, default 10, is the number of frames per game (range 1..15).
REQ-003 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 scan_code  in  8  PS/2 keyboard byte; valid only while scan_valid=1.
REQ-006 scan_valid  in  1  one-cycle strobe per received byte.
REQ-007 tick  in  1  one-cycle power-meter step enable from the rate divider.
REQ-008 x_pos  in  4  current arrow position from the aim block.
REQ-009 ball_done  in  1  level from the lane/pin logic; 1 = ball has finished rolling.
REQ-010 arrow_en  out  1  one-cycle enable to the aim block.
REQ-011 arrow_dir  out  8  direction code to the aim block: 8'h1C left, 8'h23 right, else 8'h00.
REQ-012 power  out  4  current power-meter value.
REQ-013 launch  out  1  one-cycle throw strobe.
REQ-014 launch_pos  out  4  x_pos latched at aim confirm.
REQ-015 launch_pow  out  4  power latched at power confirm.
REQ-016 frame  out  4  current frame number, 1-based.
REQ-017 ball  out  1  0 = first ball of frame, 1 = second.
REQ-018 game_over  out  1  high in DONE state.

Function
REQ-019 The FSM SHALL have states IDLE, AIM, POWER, LAUNCH, ROLL, DONE.
REQ-020 The decoder SHALL treat a scan_valid byte 8'hF0 as break prefix and discard the next scan_valid byte; only make codes act.
REQ-021 IDLE: make code 8'h29 (space) -> AIM.
REQ-022 AIM: make 8'h1C or 8'h23 -> arrow_en=1 and arrow_dir=that code in the next cycle only; no bounds checking here (aim block clamps).
REQ-023 AIM: make 8'h29 -> launch_pos<=x_pos, power<=0, POWER.
REQ-024 POWER: on tick, power ping-pongs 0,1..POWER_MAX,POWER_MAX-1..0,1..; direction flips at 0 and POWER_MAX with no repeated value.
REQ-025 POWER: make 8'h29 -> launch_pow<=power (value before any same-cycle tick update), LAUNCH; same-cycle tick is ignored.
REQ-026 LAUNCH: launch=1 for exactly one cycle, then ROLL.
REQ-027 ROLL: wait for ball_done=1; all keys ignored; then advance ball/frame.
REQ-028 Advance: ball 0 -> ball 1, AIM; ball 1 -> ball 0, frame+1, AIM; ball 1 with frame=NUM_FRAMES -> DONE.
REQ-029 DONE: game_over=1; make 8'h29 -> frame=1, ball=0, IDLE.
REQ-030 Keys other than 8'h1C/8'h23/8'h29 SHALL be ignored in every state; arrow_en SHALL be 0 outside AIM.
REQ-031 power SHALL hold its value outside POWER.

Reset
REQ-032 reset=0 SHALL immediately force IDLE, arrow_en=0, arrow_dir=0, power=0, launch=0, launch_pos=0, launch_pow=0, frame=1, ball=0, game_over=0, break-pending flag clear, including mid-throw.

Structure
REQ-033 State encoding and scan-code constants (8'h1C, 8'h23, 8'h29, 8'hF0) SHALL live in the shared game package.
REQ-034 The make/break decoder SHALL be one sub-module, ps2_make_filter, emitting make_valid and make_code.

Verification
REQ-035 Reset, space, A, A, D -> AIM; three arrow_en pulses with dir 1C,1C,23, each one cycle.
REQ-036 A then F0,1C -> one arrow_en only (break discarded).
REQ-037 Space in AIM at x_pos=7, 20 ticks with POWER_MAX=15 -> power=10; space -> launch_pos=7, launch_pow=10, one-cycle launch.
REQ-038 ball_done in ROLL twice -> ball 0->1->0, frame 1->2.
REQ-039 NUM_FRAMES=2, four full throws -> game_over=1; space -> IDLE, frame=1.
REQ-040 reset asserted during POWER at power=6 -> all outputs at reset values asynchronously.
